// File: rtl/stream_group_accu_pkg.sv
// Shared helpers for the stream group accumulator.
package stream_group_accu_pkg;

  // Beat counter width: max(1, clog2(group_len)).
  function automatic int cnt_width(input int group_len);
    return (group_len <= 2) ? 1 : $clog2(group_len);
  endfunction

endpackage

// File: rtl/stream_group_accu.sv
// Sums each run of GROUP_LEN accepted input beats into one result beat on a
// ready/valid output register; the last beat stalls only behind an unconsumed result.
module stream_group_accu
  import stream_group_accu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACCU_WIDTH = 16,
  parameter int GROUP_LEN  = 4,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idat,
  input  logic                  ivld,
  output logic                  irdy,
  output logic [ACCU_WIDTH-1:0] odat,
  output logic                  ovld,
  input  logic                  ordy
);

  localparam int CNT_WIDTH = cnt_width(GROUP_LEN);

  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [ACCU_WIDTH-1:0] accu_t;

  localparam bit   ONE_BEAT = (GROUP_LEN == 1);
  localparam cnt_t PRE_LAST = cnt_t'((GROUP_LEN > 1) ? (GROUP_LEN - 2) : 0);

  if (ACCU_WIDTH < DATA_WIDTH) begin : g_bad_accu_width
    $error("stream_group_accu: ACCU_WIDTH must be >= DATA_WIDTH");
  end
  if (GROUP_LEN < 1) begin : g_bad_group_len
    $error("stream_group_accu: GROUP_LEN must be >= 1");
  end

  cnt_t  cnt_r;
  logic  lst_r;
  accu_t accu_r;
  accu_t odat_r;
  logic  ovld_r;
  accu_t ext_s;
  accu_t sum_s;
  logic  acc_s;

  // lst_r is registered so the ready path never sees the counter compare.
  assign irdy  = !lst_r || !ovld_r || ordy;
  assign acc_s = ivld && irdy;
  assign odat  = odat_r;
  assign ovld  = ovld_r;

  // Widen the input beat to accumulator width.
  always_comb begin
    if (SIGNED) begin
      ext_s = accu_t'($signed(idat));
    end else begin
      ext_s = accu_t'(idat);
    end
  end

  // First beat of a group restarts the sum; later beats add with wraparound.
  always_comb begin
    if (cnt_r == '0) begin
      sum_s = ext_s;
    end else begin
      sum_s = accu_r + ext_s;
    end
  end

  // Counter, accumulator and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      lst_r  <= ONE_BEAT;
      accu_r <= '0;
      odat_r <= '0;
      ovld_r <= 1'b0;
    end else if (acc_s && lst_r) begin
      cnt_r  <= '0;
      lst_r  <= ONE_BEAT;
      accu_r <= sum_s;
      odat_r <= sum_s;
      ovld_r <= 1'b1;
    end else if (acc_s) begin
      cnt_r  <= cnt_r + cnt_t'(1);
      lst_r  <= (cnt_r == PRE_LAST);
      accu_r <= sum_s;
      ovld_r <= ovld_r && !ordy;
    end else begin
      ovld_r <= ovld_r && !ordy;
    end
  end

endmodule

// File: tb/tb_stream_group_accu.sv
// Self-checking bench: directed group/stall/reset cases on several configurations
// plus 1000 randomized groups checked against an arithmetic reference.
module tb_stream_group_accu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Three GROUP_LEN=3 variants share one input stream.
  logic [7:0]  idat_g = 8'd0;
  logic        ivld_g = 1'b0;
  logic        ordy_g = 1'b1;
  logic        irdy_a, irdy_b, irdy_c;
  logic        ovld_a, ovld_b, ovld_c;
  logic [9:0]  odat_a, odat_b;
  logic [7:0]  odat_c;

  logic [7:0]  idat_d = 8'd0;
  logic        ivld_d = 1'b0;
  logic        ordy_d = 1'b1;
  logic        irdy_d, ovld_d;
  logic [15:0] odat_d;

  logic [7:0]  idat_e = 8'd0;
  logic        ivld_e = 1'b0;
  logic        ordy_e = 1'b1;
  logic        irdy_e, ovld_e;
  logic [15:0] odat_e;

  stream_group_accu #(.DATA_WIDTH(8), .ACCU_WIDTH(10), .GROUP_LEN(3), .SIGNED(1'b1)) u_a (
    .clk(clk), .rst(rst), .idat(idat_g), .ivld(ivld_g), .irdy(irdy_a),
    .odat(odat_a), .ovld(ovld_a), .ordy(ordy_g));
  stream_group_accu #(.DATA_WIDTH(8), .ACCU_WIDTH(10), .GROUP_LEN(3), .SIGNED(1'b0)) u_b (
    .clk(clk), .rst(rst), .idat(idat_g), .ivld(ivld_g), .irdy(irdy_b),
    .odat(odat_b), .ovld(ovld_b), .ordy(ordy_g));
  stream_group_accu #(.DATA_WIDTH(8), .ACCU_WIDTH(8), .GROUP_LEN(3), .SIGNED(1'b0)) u_c (
    .clk(clk), .rst(rst), .idat(idat_g), .ivld(ivld_g), .irdy(irdy_c),
    .odat(odat_c), .ovld(ovld_c), .ordy(ordy_g));
  stream_group_accu #(.DATA_WIDTH(8), .ACCU_WIDTH(16), .GROUP_LEN(4), .SIGNED(1'b1)) u_d (
    .clk(clk), .rst(rst), .idat(idat_d), .ivld(ivld_d), .irdy(irdy_d),
    .odat(odat_d), .ovld(ovld_d), .ordy(ordy_d));
  stream_group_accu #(.DATA_WIDTH(8), .ACCU_WIDTH(16), .GROUP_LEN(1), .SIGNED(1'b1)) u_e (
    .clk(clk), .rst(rst), .idat(idat_e), .ivld(ivld_e), .irdy(irdy_e),
    .odat(odat_e), .ovld(ovld_e), .ordy(ordy_e));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ext_val(input logic [7:0] v, input bit sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  function automatic logic [31:0] wrap(input int s, input int w);
    return 32'(s) & ((32'd1 << w) - 32'd1);
  endfunction

  // One back-to-back group of three beats into the shared-stream variants.
  task automatic grp3(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2);
    logic [7:0] v [3];
    int sa, su;
    v[0] = v0; v[1] = v1; v[2] = v2;
    sa = 0; su = 0;
    for (int i = 0; i < 3; i++) begin
      sa += ext_val(v[i], 1'b1);
      su += ext_val(v[i], 1'b0);
    end
    ordy_g = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idat_g = v[i];
      ivld_g = 1'b1;
      @(posedge clk); #1;
      if (i < 2) chk_eq("g3_early_ovld", 32'(ovld_a), 32'd0);
    end
    ivld_g = 1'b0;
    chk_eq("g3_a_ovld", 32'(ovld_a), 32'd1);
    chk_eq("g3_a_odat", 32'(odat_a), wrap(sa, 10));
    chk_eq("g3_b_odat", 32'(odat_b), wrap(su, 10));
    chk_eq("g3_c_odat", 32'(odat_c), wrap(su, 8));
    @(posedge clk); #1;
    chk_eq("g3_a_ovld_drop", 32'(ovld_a), 32'd0);
    chk_eq("g3_c_ovld_drop", 32'(ovld_c), 32'd0);
  endtask

  // Present one beat to the GROUP_LEN=4 instance, waiting (bounded) for ready.
  task automatic beat_d(input logic [7:0] v);
    int wait_n;
    wait_n = 0;
    idat_d = v;
    ivld_d = 1'b1;
    #1;
    while (!irdy_d && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk_eq("d_beat_ready", 32'(irdy_d), 32'd1);
    @(posedge clk); #1;
    ivld_d = 1'b0;
  endtask

  logic [7:0] rdata [4000];
  int         rsum  [1000];

  initial begin
    int in_idx, n_out, s;
    logic acc, deq;

    // Reset state, observed while rst is asserted.
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_a_ovld", 32'(ovld_a), 32'd0);
    chk_eq("rst_a_odat", 32'(odat_a), 32'd0);
    chk_eq("rst_a_irdy", 32'(irdy_a), 32'd1);
    chk_eq("rst_e_irdy", 32'(irdy_e), 32'd1);
    rst = 1'b0;

    grp3(8'd5, 8'hFD, 8'd7);
    grp3(8'hFF, 8'hFF, 8'hFF);
    grp3(8'h80, 8'h81, 8'h7F);

    // Single-beat groups: one result per cycle.
    ordy_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] v;
      v = (i == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      idat_e = v;
      ivld_e = 1'b1;
      #1;
      chk_eq("e_irdy", 32'(irdy_e), 32'd1);
      @(posedge clk); #1;
      chk_eq("e_ovld", 32'(ovld_e), 32'd1);
      chk_eq("e_odat", 32'(odat_e), wrap(ext_val(v, 1'b1), 16));
    end
    ivld_e = 1'b0;

    // Stall: last beat waits while the first result is unconsumed.
    ordy_d = 1'b1;
    beat_d(8'd1); beat_d(8'd2); beat_d(8'd3); beat_d(8'd4);
    ordy_d = 1'b0;
    chk_eq("stall_first_ovld", 32'(ovld_d), 32'd1);
    chk_eq("stall_first_odat", 32'(odat_d), 32'd10);
    for (int i = 0; i < 3; i++) begin
      idat_d = 8'(5 + i);
      ivld_d = 1'b1;
      #1;
      chk_eq("stall_nonlast_irdy", 32'(irdy_d), 32'd1);
      @(posedge clk); #1;
    end
    idat_d = 8'd8;
    for (int i = 0; i < 3; i++) begin
      chk_eq("stall_last_irdy", 32'(irdy_d), 32'd0);
      chk_eq("stall_hold_odat", 32'(odat_d), 32'd10);
      chk_eq("stall_hold_ovld", 32'(ovld_d), 32'd1);
      @(posedge clk); #1;
    end
    ordy_d = 1'b1;
    #1;
    chk_eq("stall_release_irdy", 32'(irdy_d), 32'd1);
    @(posedge clk); #1;
    ivld_d = 1'b0;
    chk_eq("stall_second_ovld", 32'(ovld_d), 32'd1);
    chk_eq("stall_second_odat", 32'(odat_d), 32'd26);
    @(posedge clk); #1;
    chk_eq("stall_drain_ovld", 32'(ovld_d), 32'd0);

    // Reset with a pending result and a half-filled group.
    beat_d(8'd2); beat_d(8'd2); beat_d(8'd2); beat_d(8'd2);
    ordy_d = 1'b0;
    beat_d(8'd9); beat_d(8'd9);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_ovld", 32'(ovld_d), 32'd0);
    chk_eq("mid_rst_odat", 32'(odat_d), 32'd0);
    chk_eq("mid_rst_irdy", 32'(irdy_d), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_eq("post_rst_ovld", 32'(ovld_d), 32'd0);
    chk_eq("post_rst_odat", 32'(odat_d), 32'd0);
    chk_eq("post_rst_irdy", 32'(irdy_d), 32'd1);
    ordy_d = 1'b1;
    beat_d(8'd1); beat_d(8'd1); beat_d(8'd1); beat_d(8'd1);
    chk_eq("post_rst_sum", 32'(odat_d), 32'd4);
    chk_eq("post_rst_sum_vld", 32'(ovld_d), 32'd1);
    @(posedge clk); #1;

    // Randomized handshakes over 1000 groups.
    for (int g = 0; g < 1000; g++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        rdata[g*4+k] = 8'($urandom_range(0, 255));
        s += ext_val(rdata[g*4+k], 1'b1);
      end
      rsum[g] = int'(wrap(s, 16));
    end
    in_idx = 0;
    n_out  = 0;
    for (int cyc = 0; cyc < 20000 && n_out < 1000; cyc++) begin
      ivld_d = (in_idx < 4000) && ($urandom_range(0, 3) != 0);
      idat_d = (in_idx < 4000) ? rdata[in_idx] : 8'd0;
      ordy_d = ($urandom_range(0, 3) != 0);
      #1;
      acc = ivld_d && irdy_d;
      deq = ovld_d && ordy_d;
      if (deq) begin
        chk_eq("rand_sum", 32'(odat_d), 32'(rsum[n_out]));
        n_out++;
      end
      @(posedge clk); #1;
      if (acc) in_idx++;
    end
    ivld_d = 1'b0;
    chk_eq("rand_out_count", 32'(n_out), 32'd1000);
    chk_eq("rand_in_count", 32'(in_idx), 32'd4000);
    @(posedge clk); #1;
    chk_eq("rand_no_extra", 32'(ovld_d), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
